// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS fetch path: word width, reset/NOP words,
// the IF/ID payload record and the word-alignment helper.
package mips_pkg;

  localparam int          WORD_W    = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          PC_STEP   = 4;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
    logic              valid;
  } if_id_t;

  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] a);
    return {a[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage signal bundle: hazard/branch controls, instruction-memory port and
// the IF/ID outputs toward decode.
interface instruction_fetch_stage_if;

  logic        Freeze;
  logic        Branch_Taken;
  logic [31:0] Branch_Address;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic [31:0] PC_ID;
  logic [31:0] Instruction_ID;
  logic        Valid_ID;

  modport master (
    input  Freeze, Branch_Taken, Branch_Address, Instruction,
    output Address, PC_ID, Instruction_ID, Valid_ID
  );

  modport slave (
    output Freeze, Branch_Taken, Branch_Address, Instruction,
    input  Address, PC_ID, Instruction_ID, Valid_ID
  );

endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register: flush loads a bubble and wins over freeze, freeze holds.
module if_id_register
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_WORD = mips_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_flush,
  input  logic   i_freeze,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q.pc    <= '0;
      r_q.instr <= NOP_WORD;
      r_q.valid <= 1'b0;
    end else if (i_flush) begin
      r_q.pc    <= '0;
      r_q.instr <= NOP_WORD;
      r_q.valid <= 1'b0;
    end else if (!i_freeze) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, presents it as the instruction-memory address and
// captures the same-cycle instruction word into IF/ID.
module instruction_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR,
  parameter int          PC_STEP   = mips_pkg::PC_STEP
) (
  input  logic                       clk,
  input  logic                       rst_n,
  instruction_fetch_stage_if.master  bus
);

  localparam logic [WORD_W-1:0] STEP = WORD_W'(PC_STEP);

  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] w_pc_inc;
  if_id_t            w_if_id_d;
  if_id_t            w_if_id_q;

  // Wraps modulo 2^32 naturally from the fixed word width.
  assign w_pc_inc = r_pc + STEP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (bus.Branch_Taken) begin
      r_pc <= align_word(bus.Branch_Address);
    end else if (!bus.Freeze) begin
      r_pc <= w_pc_inc;
    end
  end

  assign w_if_id_d.pc    = w_pc_inc;
  assign w_if_id_d.instr = bus.Instruction;
  assign w_if_id_d.valid = 1'b1;

  if_id_register #(
    .NOP_WORD (NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_flush  (bus.Branch_Taken),
    .i_freeze (bus.Freeze),
    .i_d      (w_if_id_d),
    .o_q      (w_if_id_q)
  );

  assign bus.Address        = r_pc;
  assign bus.PC_ID          = w_if_id_q.pc;
  assign bus.Instruction_ID = w_if_id_q.instr;
  assign bus.Valid_ID       = w_if_id_q.valid;

endmodule
